// File: rtl/line_pkg.sv
// Shared types and constants for the Bresenham line engine.
// Optional feature macro used by the engine: LINE_CLIP_EN.
package line_pkg;

  localparam int LINE_WIDTH = 13;

  // The error term needs two bits more than a coordinate to hold err - dy
  // without wrapping.
  function automatic int errWidth(input int w);
    return w + 2;
  endfunction

  localparam int LINE_ERR_W = errWidth(LINE_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } line_state_e;

  localparam logic YSTEP_POS = 1'b0;
  localparam logic YSTEP_NEG = 1'b1;

endpackage

// File: rtl/line_setup.sv
// Combinational line setup: octant folding (steep swap), endpoint ordering
// along the major axis, deltas and minor-axis step direction.
module line_setup
  import line_pkg::*;
#(
  parameter int WIDTH = LINE_WIDTH
) (
  input  logic signed [WIDTH-1:0] x0_i,
  input  logic signed [WIDTH-1:0] y0_i,
  input  logic signed [WIDTH-1:0] x1_i,
  input  logic signed [WIDTH-1:0] y1_i,
  output logic                    steep_o,
  output logic signed [WIDTH-1:0] majStart_o,
  output logic signed [WIDTH-1:0] minStart_o,
  output logic signed [WIDTH-1:0] majEnd_o,
  output logic        [WIDTH:0]   dx_o,
  output logic        [WIDTH:0]   dy_o,
  output logic                    ystep_o
);

  logic        [WIDTH:0]   x0e, y0e, x1e, y1e;
  logic        [WIDTH:0]   adx, ady;
  logic        [WIDTH:0]   majStartE, majEndE, minStartE, minEndE;
  logic signed [WIDTH-1:0] a0, b0, a1, b1;
  logic signed [WIDTH-1:0] minEnd;
  logic                    swapped;

  // Magnitudes are taken as unsigned WIDTH+1 values: the true difference of
  // two WIDTH-bit signed numbers always fits, so modular subtraction is exact.
  always_comb begin
    x0e = {x0_i[WIDTH-1], x0_i};
    y0e = {y0_i[WIDTH-1], y0_i};
    x1e = {x1_i[WIDTH-1], x1_i};
    y1e = {y1_i[WIDTH-1], y1_i};
    adx = (x1_i >= x0_i) ? (x1e - x0e) : (x0e - x1e);
    ady = (y1_i >= y0_i) ? (y1e - y0e) : (y0e - y1e);

    steep_o = (ady > adx);
    if (steep_o) begin
      a0 = y0_i;
      b0 = x0_i;
      a1 = y1_i;
      b1 = x1_i;
    end else begin
      a0 = x0_i;
      b0 = y0_i;
      a1 = x1_i;
      b1 = y1_i;
    end

    swapped    = (a0 > a1);
    majStart_o = swapped ? a1 : a0;
    majEnd_o   = swapped ? a0 : a1;
    minStart_o = swapped ? b1 : b0;
    minEnd     = swapped ? b0 : b1;

    majStartE = {majStart_o[WIDTH-1], majStart_o};
    majEndE   = {majEnd_o[WIDTH-1], majEnd_o};
    minStartE = {minStart_o[WIDTH-1], minStart_o};
    minEndE   = {minEnd[WIDTH-1], minEnd};

    dx_o    = majEndE - majStartE;
    ystep_o = (minStart_o < minEnd) ? YSTEP_POS : YSTEP_NEG;
    dy_o    = (minEnd >= minStart_o) ? (minEndE - minStartE) : (minStartE - minEndE);
  end

endmodule

// File: rtl/bresenham_line_engine.sv
// Sequential Bresenham rasteriser: accepts one line per handshake, folds it
// into the first octant in SETUP, then streams one pixel per cycle with
// back-pressure. Define LINE_CLIP_EN to skip off-screen pixels.
module bresenham_line_engine
  import line_pkg::*;
#(
  parameter int WIDTH    = LINE_WIDTH,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic signed [WIDTH-1:0] pix_x,
  output logic signed [WIDTH-1:0] pix_y,
  output logic                    pix_last,
  output logic                    busy,
  output logic                    line_done
);

  localparam int ERR_W = errWidth(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef LINE_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  line_state_e             state_q;
  logic signed [WIDTH-1:0] epX0_q, epY0_q, epX1_q, epY1_q;
  logic                    steep_q, ystep_q;
  logic signed [WIDTH-1:0] x_q, y_q, xEnd_q;
  logic        [WIDTH:0]   dx_q, dy_q;
  logic signed [ERR_W-1:0] err_q;
  logic                    pixValid_q, pixLast_q;
  logic signed [WIDTH-1:0] pixX_q, pixY_q;
  logic                    inReady_q, busy_q, lineDone_q;

  logic                    suSteep, suYstep;
  logic signed [WIDTH-1:0] suMajStart, suMinStart, suMajEnd;
  logic        [WIDTH:0]   suDx, suDy;

  logic signed [ERR_W-1:0] errDec_d, err_d, errInit_d;
  logic signed [WIDTH-1:0] x_d, y_d;
  logic signed [WIDTH-1:0] setupPixX_d, setupPixY_d, stepPixX_d, stepPixY_d;
  logic                    setupShow_d, stepShow_d, advance_d;

  function automatic logic onScreen(input logic signed [WIDTH-1:0] px,
                                    input logic signed [WIDTH-1:0] py);
    return (int'(px) >= 0) && (int'(px) < SCREEN_W) &&
           (int'(py) >= 0) && (int'(py) < SCREEN_H);
  endfunction

  line_setup #(.WIDTH(WIDTH)) u_setup (
    .x0_i       (epX0_q),
    .y0_i       (epY0_q),
    .x1_i       (epX1_q),
    .y1_i       (epY1_q),
    .steep_o    (suSteep),
    .majStart_o (suMajStart),
    .minStart_o (suMinStart),
    .majEnd_o   (suMajEnd),
    .dx_o       (suDx),
    .dy_o       (suDy),
    .ystep_o    (suYstep)
  );

  // Next Bresenham step, first pixel of a fresh line, and clip visibility.
  always_comb begin
    errDec_d = err_q - $signed({1'b0, dy_q});
    err_d    = errDec_d;
    y_d      = y_q;
    if (errDec_d[ERR_W-1]) begin
      err_d = errDec_d + $signed({1'b0, dx_q});
      y_d   = (ystep_q == YSTEP_NEG) ? (y_q - ONE) : (y_q + ONE);
    end
    x_d = x_q + ONE;

    errInit_d   = $signed({1'b0, suDx >> 1});
    setupPixX_d = suSteep ? suMinStart : suMajStart;
    setupPixY_d = suSteep ? suMajStart : suMinStart;
    stepPixX_d  = steep_q ? y_d : x_d;
    stepPixY_d  = steep_q ? x_d : y_d;

    setupShow_d = CLIP_ON ? onScreen(setupPixX_d, setupPixY_d) : 1'b1;
    stepShow_d  = CLIP_ON ? onScreen(stepPixX_d, stepPixY_d) : 1'b1;

    advance_d = pix_ready || !pixValid_q;
  end

  // Control FSM; every output is registered so downstream sees clean timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      epX0_q     <= '0;
      epY0_q     <= '0;
      epX1_q     <= '0;
      epY1_q     <= '0;
      steep_q    <= 1'b0;
      ystep_q    <= YSTEP_POS;
      x_q        <= '0;
      y_q        <= '0;
      xEnd_q     <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      pixValid_q <= 1'b0;
      pixLast_q  <= 1'b0;
      pixX_q     <= '0;
      pixY_q     <= '0;
      inReady_q  <= 1'b1;
      busy_q     <= 1'b0;
      lineDone_q <= 1'b0;
    end else begin
      lineDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            epX0_q    <= x0;
            epY0_q    <= y0;
            epX1_q    <= x1;
            epY1_q    <= y1;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          steep_q    <= suSteep;
          ystep_q    <= suYstep;
          x_q        <= suMajStart;
          y_q        <= suMinStart;
          xEnd_q     <= suMajEnd;
          dx_q       <= suDx;
          dy_q       <= suDy;
          err_q      <= errInit_d;
          pixX_q     <= setupPixX_d;
          pixY_q     <= setupPixY_d;
          pixValid_q <= setupShow_d;
          pixLast_q  <= (suMajStart == suMajEnd) && setupShow_d;
          state_q    <= DRAW;
        end
        DRAW: begin
          if (advance_d) begin
            if (x_q == xEnd_q) begin
              pixValid_q <= 1'b0;
              pixLast_q  <= 1'b0;
              lineDone_q <= 1'b1;
              inReady_q  <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              x_q        <= x_d;
              y_q        <= y_d;
              err_q      <= err_d;
              pixX_q     <= stepPixX_d;
              pixY_q     <= stepPixY_d;
              pixValid_q <= stepShow_d;
              pixLast_q  <= (x_d == xEnd_q) && stepShow_d;
            end
          end
        end
        default: begin
          pixValid_q <= 1'b0;
          pixLast_q  <= 1'b0;
          inReady_q  <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign pix_valid = pixValid_q;
  assign pix_x     = pixX_q;
  assign pix_y     = pixY_q;
  assign pix_last  = pixLast_q;
  assign busy      = busy_q;
  assign line_done = lineDone_q;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Scoreboard bench for bresenham_line_engine: directed lines push their
// hand-computed pixels into a queue; a monitor pops and compares on every
// pixel handshake. Honours LINE_CLIP_EN for the clipping scenario.
module tb_bresenham_line_engine;

  localparam int W = 13;

  typedef struct packed {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic                last;
  } pix_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x0, y0, x1, y1;
  logic                pix_valid;
  logic                pix_ready;
  logic signed [W-1:0] pix_x, pix_y;
  logic                pix_last;
  logic                busy;
  logic                line_done;

  int   errors = 0;
  int   checks = 0;
  int   doneCount = 0;
  int   expDone = 0;
  pix_t expQ[$];
  pix_t stallPix;
  logic prevStall = 1'b0;

  bresenham_line_engine #(.WIDTH(W), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy),
    .line_done (line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic pushPix(input int px, input int py, input logic last);
    pix_t p;
    p.x    = W'(px);
    p.y    = W'(py);
    p.last = last;
    expQ.push_back(p);
  endtask

  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x0 = W'(ax0);
    y0 = W'(ay0);
    x1 = W'(ax1);
    y1 = W'(ay1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) reportTimeout("acceptWait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) reportTimeout("idleWait");
  endtask

  task automatic finishLine(input string name);
    @(negedge clk);
    checkOutput({name, "_queueEmpty"}, expQ.size(), 0);
    checkOutput({name, "_lineDone"}, doneCount, expDone);
  endtask

  // Monitor: pops the scoreboard on each pixel handshake and checks that a
  // stalled pixel stays put until it is accepted.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (prevStall && rst_n)
        checkOutput("stallHold", {pix_valid, pix_x, pix_y, pix_last},
                    {1'b1, stallPix.x, stallPix.y, stallPix.last});
      prevStall = 1'b0;
      if (line_done) doneCount++;
      if (pix_valid && pix_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPixel: got (%0d,%0d) last=%0b, expected no pixel",
                   pix_x, pix_y, pix_last);
        end else begin
          e = expQ.pop_front();
          checkOutput("pixel", {pix_x, pix_y, pix_last}, {e.x, e.y, e.last});
        end
      end else if (pix_valid && !pix_ready) begin
        prevStall = 1'b1;
        stallPix.x = pix_x;
        stallPix.y = pix_y;
        stallPix.last = pix_last;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected run to end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    pix_ready = 1'b1;
    x0 = '0;
    y0 = '0;
    x1 = '0;
    y1 = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstPixValid", pix_valid, 0);
    checkOutput("rstPixXY", {pix_x, pix_y}, 0);
    checkOutput("rstPixLast", pix_last, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLineDone", line_done, 0);
    rst_n = 1'b1;

    $display("[TB] horizontal line (0,0)->(4,0)");
    pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 0, 0); pushPix(3, 0, 0); pushPix(4, 0, 1);
    applyStimulus(0, 0, 4, 0);
    @(negedge clk);
    checkOutput("setupNoPixel", pix_valid, 0);
    checkOutput("setupBusy", busy, 1);
    checkOutput("setupInReady", in_ready, 0);
    @(negedge clk);
    checkOutput("firstPixLatency", pix_valid, 1);
    waitIdle(n);
    checkOutput("lineLatency", n + 2, 7);
    expDone++;
    finishLine("horiz");

    $display("[TB] steep line (0,0)->(1,3)");
    pushPix(0, 0, 0); pushPix(0, 1, 0); pushPix(1, 2, 0); pushPix(1, 3, 1);
    applyStimulus(0, 0, 1, 3);
    waitIdle(n);
    expDone++;
    finishLine("steep");

    $display("[TB] reversed line (4,2)->(0,0)");
    pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 1, 0); pushPix(3, 1, 0); pushPix(4, 2, 1);
    applyStimulus(4, 2, 0, 0);
    waitIdle(n);
    expDone++;
    finishLine("reversed");

    $display("[TB] negative ystep (0,3)->(3,0)");
    pushPix(0, 3, 0); pushPix(1, 2, 0); pushPix(2, 1, 0); pushPix(3, 0, 1);
    applyStimulus(0, 3, 3, 0);
    waitIdle(n);
    expDone++;
    finishLine("negYstep");

    $display("[TB] degenerate line (5,5)->(5,5)");
    pushPix(5, 5, 1);
    applyStimulus(5, 5, 5, 5);
    waitIdle(n);
    expDone++;
    finishLine("degenerate");

    $display("[TB] back-pressure on (0,0)->(4,2)");
    pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 1, 0); pushPix(3, 1, 0); pushPix(4, 2, 1);
    pix_ready = 1'b0;
    applyStimulus(0, 0, 4, 2);
    repeat (3) @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      pix_ready = 1'($urandom_range(0, 1));
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) reportTimeout("backPressureIdle");
    pix_ready = 1'b1;
    expDone++;
    finishLine("backPressure");

    $display("[TB] reset in the middle of (0,0)->(4,2)");
    pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 1, 0); pushPix(3, 1, 0); pushPix(4, 2, 1);
    applyStimulus(0, 0, 4, 2);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (expQ.size() != 3 && n < 20);
    if (expQ.size() != 3) reportTimeout("thirdPixel");
    rst_n = 1'b0;
    #1;
    checkOutput("midRstPixValid", pix_valid, 0);
    checkOutput("midRstInReady", in_ready, 1);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstLineDone", line_done, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    finishLine("midReset");

    $display("[TB] negative coordinates (-3,-1)->(-1,-2)");
`ifndef LINE_CLIP_EN
    pushPix(-3, -1, 0); pushPix(-2, -1, 0); pushPix(-1, -2, 1);
`endif
    applyStimulus(-3, -1, -1, -2);
    waitIdle(n);
    expDone++;
    finishLine("negCoords");

    $display("[TB] partly off-screen line (-2,0)->(2,0)");
`ifdef LINE_CLIP_EN
    pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 0, 1);
`else
    pushPix(-2, 0, 0); pushPix(-1, 0, 0); pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 0, 1);
`endif
    applyStimulus(-2, 0, 2, 0);
    waitIdle(n);
    expDone++;
    finishLine("clipLine");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Sequential, parametrised Bresenham line rasteriser for the line-drawing core. It accepts one line (two signed endpoints) per valid/ready transaction and registers the steep/swap/delta/ystep setup once. It then streams one pixel coordinate per cycle to the fragment stage over a valid/ready handshake with back-pressure. It sits between primitive assembly and the pixel writer, replacing the purely combinational parameter stage plus external stepping logic.

## Interface
- WIDTH, 13, signed two's-complement coordinate width (inputs and outputs)
- SCREEN_W, 640, clip width in pixels; used only under LINE_CLIP_EN
- SCREEN_H, 480, clip height in pixels; used only under LINE_CLIP_EN
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- in_valid  in  1  endpoint set valid
- in_ready  out  1  engine can accept a line; high only in IDLE
- x0, y0, x1, y1  in  WIDTH each  signed endpoints; sampled on in_valid && in_ready
- pix_valid  out  1  pix_x/pix_y hold a pixel
- pix_ready  in  1  downstream accepts pixel
- pix_x, pix_y  out  WIDTH each  signed pixel coordinate
- pix_last  out  1  qualifies the final iteration's pixel
- busy  out  1  high in SETUP or DRAW
- line_done  out  1  one-cycle pulse when the final iteration retires

## Operation
- States: IDLE -> SETUP -> DRAW -> IDLE.
- IDLE: in_ready=1. On handshake, register the endpoints and go to SETUP.
- SETUP (1 cycle): steep = |y1-y0| > |x1-x0|. If steep, swap x<->y in both endpoints. If x0>x1, swap the endpoints. dx = x1-x0; dy = |y1-y0|; ystep = +1 if y0<y1, else -1. err = dx>>>1; x = x0; y = y0. Go to DRAW.
- Arithmetic: differences in WIDTH+1 bits; err register is WIDTH+2 bits signed. No overflow is possible for any WIDTH-bit inputs.
- DRAW, per iteration:
  - Present pixel (steep ? (y,x) : (x,y)).
  - On handshake: err' = err-dy. If err'<0, then y += ystep and err' += dx. Then x += 1.
  - Iterations run x = x0..x1 inclusive, giving dx+1 pixels.
- pix_last=1 exactly when x==x1. On the handshake of that pixel: line_done pulses and the next state is IDLE.
- Pixel order follows the swapped endpoints, i.e. ascending major axis, not input order.
- Degenerate line (identical endpoints): exactly one pixel, with pix_last=1.
- Stall: while pix_valid && !pix_ready, pix_x, pix_y and pix_last hold stable and no state advances.
- in_valid is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - pix_valid=0, pix_x=0, pix_y=0, pix_last=0.
  - busy=0, line_done=0.
  - All internal registers 0.
- Input handshake at edge T: SETUP in cycle T+1, first pixel_valid in cycle T+2.
- Throughput: one pixel per cycle with pix_ready held high.
- Line latency (no stalls): dx+3 cycles from accept to the next in_ready.
- After the last pixel handshake, there is one IDLE cycle before the next accept is possible.
- Reset mid-line: asynchronous return to IDLE. pix_valid drops immediately, with no line_done. The partial line is discarded.

## Configuration
- LINE_CLIP_EN defined:
  - An iteration whose pixel lies outside 0<=px<SCREEN_W and 0<=py<SCREEN_H advances in one cycle with pix_valid=0.
  - pix_last is asserted only if the final pixel is visible.
  - line_done still pulses when the final iteration retires.
- LINE_CLIP_EN undefined:
  - Every iteration is presented.
  - SCREEN_W and SCREEN_H are unused.
  - pix_last marks the final pixel.

## Structure
- Package line_pkg holds:
  - the WIDTH default;
  - the state enum (IDLE, SETUP, DRAW);
  - the YSTEP_POS / YSTEP_NEG constants;
  - the error-width localparam (WIDTH+2).
- Sub-module line_setup: combinational steep/swap/delta/ystep computation, registered by the FSM in SETUP.

## Test plan
- (0,0)->(4,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0),(4,0). pix_last and line_done on (4,0). First pix_valid 2 cycles after accept.
- Steep (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3).
- Reversed endpoints (4,2)->(0,0) -> (0,0),(1,0),(2,1),(3,1),(4,2).
- Negative ystep (0,3)->(3,0) -> (0,3),(1,2),(2,1),(3,0).
- Back-pressure: toggle pix_ready randomly on (0,0)->(4,2) -> same 5 pixels, stable while stalled. Then reset mid-line (rst_n low at the 3rd pixel) -> pix_valid=0 immediately, in_ready=1, no line_done.
- LINE_CLIP_EN: (-2,0)->(2,0) -> only (0,0),(1,0),(2,0) presented; pix_last on (2,0); line_done one pulse.
